// File: rtl/imem_loader_if.sv
// Bus between the boot controller / byte source and the instruction-memory loader.
// The master side drives start and the byte stream; the loader sits on the slave side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  i_start;
    logic                  i_rx_valid;
    logic [7:0]            i_rx_data;
    logic                  o_rx_ready;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [15:0]           o_mem_wdata;
    logic                  o_ctrl_Busy;
    logic                  o_done;
    logic                  o_err;
    logic [1:0]            o_err_code;

    modport master (
        output i_start, i_rx_valid, i_rx_data,
        input  o_rx_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_ctrl_Busy, o_done, o_err, o_err_code
    );

    modport slave (
        input  i_start, i_rx_valid, i_rx_data,
        output o_rx_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_ctrl_Busy, o_done, o_err, o_err_code
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-image loader: parses a length/payload/checksum byte frame and writes
// little-endian halfwords into instruction memory while holding the pipeline stalled.
module imem_loader #(
    parameter int MEMORY_WIDTH = 16,
    parameter int MEMORY_DEPTH = 2**10,
    parameter int ADDR_WIDTH   = 10,
    parameter int BASE_ADDR    = 0,
    parameter int TIMEOUT      = 1024
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_LO  = 4'd1;
    localparam logic [3:0] S_LEN_HI  = 4'd2;
    localparam logic [3:0] S_DATA_LO = 4'd3;
    localparam logic [3:0] S_DATA_HI = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_CHK     = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    localparam logic [16:0]   LIMIT  = 17'(MEMORY_DEPTH - BASE_ADDR);
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [3:0]    state, state_next;
    logic [1:0]    code_next;
    logic [7:0]    len_lo, lo_byte, chk;
    logic [15:0]   len, k, len_in;
    logic [16:0]   k_inc;
    logic [TW-1:0] timer;
    logic          accept, start_ok;

    function automatic logic receiving(input logic [3:0] s);
        return s inside {S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHK};
    endfunction

    function automatic logic stopped(input logic [3:0] s);
        return s inside {S_IDLE, S_DONE, S_ERR};
    endfunction

    always_comb begin
        accept     = bus.i_rx_valid && bus.o_rx_ready;
        start_ok   = bus.i_start && stopped(state);
        len_in     = {bus.i_rx_data, len_lo};
        k_inc      = {1'b0, k} + 17'd1;
        state_next = state;
        code_next  = bus.o_err_code;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    state_next = S_LEN_LO;
                    code_next  = 2'd0;
                end
            end
            S_LEN_LO:  if (accept) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_in} > LIMIT) begin
                        state_next = S_ERR;
                        code_next  = 2'd1;
                    end else if (len_in == 16'd0) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: if (accept) state_next = S_DATA_HI;
            S_DATA_HI: if (accept) state_next = S_WRITE;
            S_WRITE:   state_next = (k_inc < {1'b0, len}) ? S_DATA_LO : S_CHK;
            S_CHK: begin
                if (accept) begin
                    if (bus.i_rx_data == chk) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERR;
                        code_next  = 2'd2;
                    end
                end
            end
            default:   state_next = S_IDLE;
        endcase
        // Idle-wait expiry overrides whatever the receiving state would do.
        if (bus.o_rx_ready && !bus.i_rx_valid && timer == T_LAST) begin
            state_next = S_ERR;
            code_next  = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            len_lo          <= '0;
            lo_byte         <= '0;
            chk             <= '0;
            len             <= '0;
            k               <= '0;
            timer           <= '0;
            bus.o_rx_ready  <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_ctrl_Busy <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_err       <= 1'b0;
            bus.o_err_code  <= '0;
        end else begin
            state           <= state_next;
            bus.o_err_code  <= code_next;
            bus.o_rx_ready  <= receiving(state_next);
            bus.o_mem_we    <= (state_next == S_WRITE);
            bus.o_ctrl_Busy <= !stopped(state_next);
            bus.o_done      <= (state_next == S_DONE);
            bus.o_err       <= (state_next == S_ERR);

            if (start_ok) begin
                chk   <= '0;
                timer <= '0;
                k     <= '0;
            end else if (accept) begin
                timer <= '0;
            end else if (bus.o_rx_ready) begin
                timer <= timer + TW'(1);
            end

            if (accept) begin
                case (state)
                    S_LEN_LO:  len_lo <= bus.i_rx_data;
                    S_LEN_HI:  len    <= len_in;
                    S_DATA_LO: begin
                        lo_byte <= bus.i_rx_data;
                        chk     <= chk ^ bus.i_rx_data;
                    end
                    S_DATA_HI: begin
                        chk             <= chk ^ bus.i_rx_data;
                        bus.o_mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + k[ADDR_WIDTH-1:0];
                        bus.o_mem_wdata <= MEMORY_WIDTH'({bus.i_rx_data, lo_byte});
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE) k <= k + 16'd1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with hand-computed writes, checksums,
// length limit, timeout, start-while-busy and reset in the write cycle.
module tb_imem_loader;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    int          wr_count;
    int          overlap;
    logic [9:0]  wr_addr [0:3];
    logic [15:0] wr_data [0:3];
    logic [15:0] mem_model [0:1023];
    logic [9:0]  last_addr;
    logic [15:0] last_data;

    imem_loader_if #(.ADDR_WIDTH(10)) bus ();

    imem_loader #(
        .MEMORY_WIDTH(16),
        .MEMORY_DEPTH(1024),
        .ADDR_WIDTH(10),
        .BASE_ADDR(0),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every write strobe seen on a clock edge.
    always @(posedge clk) begin
        if (bus.o_mem_we) begin
            if (wr_count < 4) begin
                wr_addr[wr_count[1:0]] = bus.o_mem_addr;
                wr_data[wr_count[1:0]] = bus.o_mem_wdata;
            end
            mem_model[bus.o_mem_addr] = bus.o_mem_wdata;
            last_addr = bus.o_mem_addr;
            last_data = bus.o_mem_wdata;
            wr_count++;
            if (bus.o_rx_ready) overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // Present a byte and hold it until the loader accepts it; leaves valid high.
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (bus.o_rx_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        if (!got) begin
            vectors++;
            assert (got) else begin
                miscompares++;
                $error("FAIL accept_wait: byte 0x%0h not accepted after %0d cycles", b, n);
            end
        end
    endtask

    task automatic idle_bus();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(bus.o_mem_we), 32'd0);
        check({tag, "_rdy"},   32'(bus.o_rx_ready), 32'd0);
        check({tag, "_busy"},  32'(bus.o_ctrl_Busy), 32'd0);
        check({tag, "_done"},  32'(bus.o_done), 32'd0);
        check({tag, "_err"},   32'(bus.o_err), 32'd0);
        check({tag, "_code"},  32'(bus.o_err_code), 32'd0);
        check({tag, "_addr"},  32'(bus.o_mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.o_mem_wdata), 32'd0);
    endtask

    initial begin
        int          base;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  exp_chk;

        vectors     = 0;
        miscompares = 0;
        wr_count    = 0;
        overlap     = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: N=2, halfwords 0x0013, 0x0000, checksum 0x13
        pulse_start();
        check("t1_busy_after_start", 32'(bus.o_ctrl_Busy), 32'd1);
        check("t1_ready_len_lo", 32'(bus.o_rx_ready), 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        check("t1_we_latency", 32'(bus.o_mem_we), 32'd1);
        check("t1_ready_in_write", 32'(bus.o_rx_ready), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13);
        idle_bus();
        check("t1_done", 32'(bus.o_done), 32'd1);
        check("t1_busy", 32'(bus.o_ctrl_Busy), 32'd0);
        check("t1_err", 32'(bus.o_err), 32'd0);
        check("t1_wr_count", 32'(wr_count), 32'd2);
        check("t1_addr0", 32'(wr_addr[0]), 32'd0);
        check("t1_data0", 32'(wr_data[0]), 32'h0013);
        check("t1_addr1", 32'(wr_addr[1]), 32'd1);
        check("t1_data1", 32'(wr_data[1]), 32'h0000);

        // Exactly MEMORY_DEPTH halfwords, back-to-back: accepted, no lost byte
        base    = wr_count;
        exp_chk = 8'h00;
        pulse_start();
        send_byte(8'h00); send_byte(8'h04);
        for (int i = 0; i < 1024; i++) begin
            lo = i[7:0];
            hi = i[15:8];
            exp_chk = exp_chk ^ lo ^ hi;
            send_byte(lo);
            send_byte(hi);
        end
        send_byte(exp_chk);
        idle_bus();
        check("full_done", 32'(bus.o_done), 32'd1);
        check("full_wr_count", 32'(wr_count - base), 32'd1024);
        check("full_last_addr", 32'(last_addr), 32'd1023);
        check("full_last_data", 32'(last_data), 32'h03FF);
        check("full_mid_data", 32'(mem_model[512]), 32'h0200);

        // Test 2: payload 93 00 50 00, checksum sent 0x00 instead of 0xC3
        base = wr_count;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        send_byte(8'h50); send_byte(8'h00);
        send_byte(8'h00);
        idle_bus();
        check("t2_err", 32'(bus.o_err), 32'd1);
        check("t2_code", 32'(bus.o_err_code), 32'd2);
        check("t2_done", 32'(bus.o_done), 32'd0);
        check("t2_busy", 32'(bus.o_ctrl_Busy), 32'd0);
        check("t2_wr_count", 32'(wr_count - base), 32'd2);
        check("t2_data0", 32'(mem_model[0]), 32'h0093);
        check("t2_data1", 32'(mem_model[1]), 32'h0050);

        // Test 3: N=0x0401 exceeds depth
        base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h04);
        idle_bus();
        check("t3_err", 32'(bus.o_err), 32'd1);
        check("t3_code", 32'(bus.o_err_code), 32'd1);
        check("t3_ready", 32'(bus.o_rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_write", 32'(wr_count - base), 32'd0);

        // Test 4: N=0, CHK=00 -> DONE, no writes
        base = wr_count;
        pulse_start();
        check("t4_err_cleared", 32'(bus.o_err), 32'd0);
        check("t4_code_cleared", 32'(bus.o_err_code), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t4_done", 32'(bus.o_done), 32'd1);
        bus.i_rx_data = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        check("t4_ready_in_done", 32'(bus.o_rx_ready), 32'd0);
        check("t4_still_done", 32'(bus.o_done), 32'd1);
        check("t4_no_write", 32'(wr_count - base), 32'd0);
        idle_bus();
        pulse_start();
        check("t4_done_cleared", 32'(bus.o_done), 32'd0);
        check("t4_busy_restart", 32'(bus.o_ctrl_Busy), 32'd1);

        // start while loading is ignored: the next two bytes stay payload
        base = wr_count;
        send_byte(8'h01); send_byte(8'h00);
        idle_bus();
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h11);
        idle_bus();
        check("t4b_done", 32'(bus.o_done), 32'd1);
        check("t4b_wr_count", 32'(wr_count - base), 32'd1);
        check("t4b_data", 32'(last_data), 32'hBBAA);

        // Test 5: stall after the first payload byte, TIMEOUT=16
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h55);
        idle_bus();
        repeat (15) @(posedge clk);
        #1;
        check("t5_no_err_at_15", 32'(bus.o_err), 32'd0);
        check("t5_ready_at_15", 32'(bus.o_rx_ready), 32'd1);
        @(posedge clk);
        #1;
        check("t5_err_at_16", 32'(bus.o_err), 32'd1);
        check("t5_code", 32'(bus.o_err_code), 32'd3);
        check("t5_ready", 32'(bus.o_rx_ready), 32'd0);
        check("t5_busy", 32'(bus.o_ctrl_Busy), 32'd0);

        // Test 6: reset asserted during the WRITE cycle
        base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34);
        check("t6_we_before_rst", 32'(bus.o_mem_we), 32'd1);
        check("t6_wdata_before_rst", 32'(bus.o_mem_wdata), 32'h3412);
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        idle_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("t6_after");
        check("t6_no_write", 32'(wr_count - base), 32'd0);
        check("we_ready_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
